pipe_front_regs: RTL and testbench
==================================

Name: pipe_front_regs

Overview:
- Front-end pipeline state for the 5-stage RISC-V core: PC register, IF/ID register and ID/EX control register.
- Consumes the load-use stall controls (PC_Write, IF_ID_Write, Bubble_Insertion) and the ID-stage branch flush.
- Produces EX_Rd_o / EX_MemRead_o, which feed back into hazard detection.
- Keeps saturating stall/bubble/flush counters and a sticky error flag for inconsistent control combinations.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset
CTRL_W, 8, width of ID/EX control bundle (excluding MemRead)
COUNT_W, 16, width of each performance counter
NOP_INSTR, 32'h0000_0013, instruction injected on reset/flush (addi x0,x0,0)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous active-high reset
PC_Write_i  input  1  1 = PC may advance, 0 = hold PC
IF_ID_Write_i  input  1  1 = IF/ID may load, 0 = hold IF/ID
Bubble_Insertion_i  input  1  1 = load bubble into ID/EX
Flush_i  input  1  branch taken in ID; discard fetched instruction
Branch_Target_i  input  32  next PC when flush taken
Instr_i  input  32  instruction memory data at address PC_o
ID_Ctrl_i  input  CTRL_W  decoded control bundle of ID instruction
ID_MemRead_i  input  1  ID instruction is a load
ID_Rd_i  input  5  ID instruction destination register
PC_o  output  32  current fetch address
IF_ID_PC_o  output  32  PC of instruction in IF/ID
IF_ID_Instr_o  output  32  instruction in IF/ID
IF_ID_Valid_o  output  1  IF/ID holds a real instruction
EX_Ctrl_o  output  CTRL_W  control bundle in ID/EX
EX_MemRead_o  output  1  ID/EX instruction is a load
EX_Rd_o  output  5  ID/EX destination register
EX_Valid_o  output  1  ID/EX holds a real instruction
Stall_Cnt_o  output  COUNT_W  cycles with PC_Write_i=0
Bubble_Cnt_o  output  COUNT_W  bubbles inserted
Flush_Cnt_o  output  COUNT_W  flushes taken
Error_o  output  1  sticky: inconsistent stall controls seen

Behaviour:
- Reset (rst_i=1 at edge):
  - PC_o=RESET_PC, IF_ID_PC_o=0, IF_ID_Instr_o=NOP_INSTR, IF_ID_Valid_o=0.
  - EX_Ctrl_o=0, EX_MemRead_o=0, EX_Rd_o=0, EX_Valid_o=0.
  - All counters 0, Error_o=0.
  - Reset overrides every other input, including mid-stall or mid-flush.
- stall := (PC_Write_i==0). take_flush := Flush_i && !stall; Flush_i is ignored while stalled because branch operands are not yet valid.
- PC update:
  - stall: hold.
  - Else take_flush: PC_o <= Branch_Target_i.
  - Else PC_o <= PC_o + 4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
- IF/ID update:
  - IF_ID_Write_i==0: hold all three fields.
  - Else take_flush: Instr <= NOP_INSTR, Valid <= 0, PC <= PC_o.
  - Else Instr <= Instr_i, PC <= PC_o, Valid <= 1.
- ID/EX update:
  - Bubble_Insertion_i==1: Ctrl <= 0, MemRead <= 0, Rd <= 0, Valid <= 0.
  - Else Ctrl <= ID_Ctrl_i, MemRead <= ID_MemRead_i, Rd <= ID_Rd_i, Valid <= IF_ID_Valid_o.
  - When IF_ID_Valid_o==0 the control fields still load as-is; decode supplies zeros for NOP.
- Latency: one cycle from each input to its register. EX_Rd_o / EX_MemRead_o are registered only, with no combinational path from any input.
- Counters, each saturating at all-ones (no wrap), updated on every non-reset edge:
  - Stall_Cnt +1 when stall.
  - Bubble_Cnt +1 when Bubble_Insertion_i.
  - Flush_Cnt +1 when take_flush.
- Error_o is set and held until reset when either condition occurs on a clock edge:
  - PC_Write_i != IF_ID_Write_i.
  - Bubble_Insertion_i != !PC_Write_i.
- Registers still update per the rules above regardless of Error_o.
- Simultaneous flush + bubble with PC_Write_i=1 (legal, e.g. branch after non-load): PC <= target, IF/ID <= NOP, ID/EX <= bubble. Counts: Flush +1, Bubble +1, and Error_o is set by the consistency rule.

Test Plan:
1. Release reset, controls 1/1/0, Instr_i=32'h0050_0093, no flush -> after 1 edge PC_o=4, IF_ID_Instr_o=32'h0050_0093, IF_ID_Valid_o=1, IF_ID_PC_o=0. After 2nd edge EX_Valid_o=1.
2. Load in ID (ID_MemRead_i=1, ID_Rd_i=5), then one cycle PC_Write_i=0, IF_ID_Write_i=0, Bubble_Insertion_i=1 -> during the bubble cycle, EX_MemRead_o=1, EX_Rd_o=5. PC_o and IF/ID unchanged across that edge. After it, EX_Valid_o=0, EX_Rd_o=0, Stall_Cnt_o=1, Bubble_Cnt_o=1, Error_o=0.
3. PC_o=32'h40, Flush_i=1, Branch_Target_i=32'h100, no stall -> PC_o=32'h100, IF_ID_Instr_o=32'h0000_0013, IF_ID_Valid_o=0, Flush_Cnt_o=1.
4. Flush_i=1 together with stall (0/0/1) -> PC_o held, IF/ID held, Flush_Cnt_o unchanged, Stall_Cnt_o +1.
5. Drive PC_Write_i=1, IF_ID_Write_i=0 for one cycle -> Error_o=1 and stays 1 after inputs return consistent; cleared only by rst_i.
6. COUNT_W=4, hold stall 20 cycles -> Stall_Cnt_o reaches 15 and stays 15. Assert rst_i mid-stall -> next edge all counters 0, PC_o=RESET_PC.

Source files
------------

// File: rtl/pipe_front_regs_if.sv
// Hazard-control bundle between the hazard/branch unit and the front-end registers.
// The hazard unit drives it (master); pipe_front_regs consumes it (slave).
interface pipe_front_regs_if;
  logic        PC_Write_i;
  logic        IF_ID_Write_i;
  logic        Bubble_Insertion_i;
  logic        Flush_i;
  logic [31:0] Branch_Target_i;

  modport master (
    output PC_Write_i, IF_ID_Write_i, Bubble_Insertion_i, Flush_i, Branch_Target_i
  );
  modport slave (
    input  PC_Write_i, IF_ID_Write_i, Bubble_Insertion_i, Flush_i, Branch_Target_i
  );
endinterface

// File: rtl/pipe_front_regs.sv
// Front-end pipeline state: PC, IF/ID and ID/EX registers with stall/bubble/flush
// handling, saturating event counters and a sticky stall-control consistency flag.
module pipe_front_regs #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned CTRL_W    = 8,
  parameter int unsigned COUNT_W   = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk_i,
  input  logic                rst_i,
  pipe_front_regs_if.slave    ctl,
  input  logic [31:0]         Instr_i,
  input  logic [CTRL_W-1:0]   ID_Ctrl_i,
  input  logic                ID_MemRead_i,
  input  logic [4:0]          ID_Rd_i,
  output logic [31:0]         PC_o,
  output logic [31:0]         IF_ID_PC_o,
  output logic [31:0]         IF_ID_Instr_o,
  output logic                IF_ID_Valid_o,
  output logic [CTRL_W-1:0]   EX_Ctrl_o,
  output logic                EX_MemRead_o,
  output logic [4:0]          EX_Rd_o,
  output logic                EX_Valid_o,
  output logic [COUNT_W-1:0]  Stall_Cnt_o,
  output logic [COUNT_W-1:0]  Bubble_Cnt_o,
  output logic [COUNT_W-1:0]  Flush_Cnt_o,
  output logic                Error_o
);

  logic stall;
  logic take_flush;
  logic ctrl_inconsistent;

  // Branch operands are not valid while stalled, so a flush is only honoured when PC advances.
  always_comb begin
    stall             = !ctl.PC_Write_i;
    take_flush        = ctl.Flush_i && !stall;
    ctrl_inconsistent = (ctl.PC_Write_i != ctl.IF_ID_Write_i) ||
                        (ctl.Bubble_Insertion_i != !ctl.PC_Write_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      PC_o          <= RESET_PC;
      IF_ID_PC_o    <= '0;
      IF_ID_Instr_o <= NOP_INSTR;
      IF_ID_Valid_o <= 1'b0;
      EX_Ctrl_o     <= '0;
      EX_MemRead_o  <= 1'b0;
      EX_Rd_o       <= '0;
      EX_Valid_o    <= 1'b0;
      Stall_Cnt_o   <= '0;
      Bubble_Cnt_o  <= '0;
      Flush_Cnt_o   <= '0;
      Error_o       <= 1'b0;
    end else begin
      if (!stall) begin
        PC_o <= take_flush ? ctl.Branch_Target_i : PC_o + 32'd4;
      end

      if (ctl.IF_ID_Write_i) begin
        IF_ID_PC_o <= PC_o;
        if (take_flush) begin
          IF_ID_Instr_o <= NOP_INSTR;
          IF_ID_Valid_o <= 1'b0;
        end else begin
          IF_ID_Instr_o <= Instr_i;
          IF_ID_Valid_o <= 1'b1;
        end
      end

      if (ctl.Bubble_Insertion_i) begin
        EX_Ctrl_o    <= '0;
        EX_MemRead_o <= 1'b0;
        EX_Rd_o      <= '0;
        EX_Valid_o   <= 1'b0;
      end else begin
        EX_Ctrl_o    <= ID_Ctrl_i;
        EX_MemRead_o <= ID_MemRead_i;
        EX_Rd_o      <= ID_Rd_i;
        EX_Valid_o   <= IF_ID_Valid_o;
      end

      if (stall && (Stall_Cnt_o != '1)) begin
        Stall_Cnt_o <= Stall_Cnt_o + 1'b1;
      end
      if (ctl.Bubble_Insertion_i && (Bubble_Cnt_o != '1)) begin
        Bubble_Cnt_o <= Bubble_Cnt_o + 1'b1;
      end
      if (take_flush && (Flush_Cnt_o != '1)) begin
        Flush_Cnt_o <= Flush_Cnt_o + 1'b1;
      end

      if (ctrl_inconsistent) begin
        Error_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_front_regs.sv
// Self-checking bench for pipe_front_regs: directed vector table, saturation/reset
// sequences, then randomized traffic against a behavioural reference model.
module tb_pipe_front_regs;
  localparam int unsigned CW  = 8;
  localparam int unsigned NW  = 4;
  localparam int          SAT = (1 << NW) - 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic           clk = 1'b0;
  logic           rst;
  logic [31:0]    instr;
  logic [CW-1:0]  id_ctrl;
  logic           id_mr;
  logic [4:0]     id_rd;
  logic [31:0]    pc, ifid_pc, ifid_instr;
  logic           ifid_v, ex_mr, ex_v, err;
  logic [CW-1:0]  ex_ctrl;
  logic [4:0]     ex_rd;
  logic [NW-1:0]  st_cnt, bu_cnt, fl_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  pipe_front_regs_if ctl ();

  pipe_front_regs #(
    .RESET_PC  (32'h0000_0000),
    .CTRL_W    (CW),
    .COUNT_W   (NW),
    .NOP_INSTR (NOP)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .ctl           (ctl.slave),
    .Instr_i       (instr),
    .ID_Ctrl_i     (id_ctrl),
    .ID_MemRead_i  (id_mr),
    .ID_Rd_i       (id_rd),
    .PC_o          (pc),
    .IF_ID_PC_o    (ifid_pc),
    .IF_ID_Instr_o (ifid_instr),
    .IF_ID_Valid_o (ifid_v),
    .EX_Ctrl_o     (ex_ctrl),
    .EX_MemRead_o  (ex_mr),
    .EX_Rd_o       (ex_rd),
    .EX_Valid_o    (ex_v),
    .Stall_Cnt_o   (st_cnt),
    .Bubble_Cnt_o  (bu_cnt),
    .Flush_Cnt_o   (fl_cnt),
    .Error_o       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic pcw, input logic ifw, input logic bub, input logic fl,
                       input logic [31:0] tgt, input logic [31:0] ins, input logic mr,
                       input logic [4:0] rd, input logic [CW-1:0] c);
    ctl.PC_Write_i         = pcw;
    ctl.IF_ID_Write_i      = ifw;
    ctl.Bubble_Insertion_i = bub;
    ctl.Flush_i            = fl;
    ctl.Branch_Target_i    = tgt;
    instr                  = ins;
    id_mr                  = mr;
    id_rd                  = rd;
    id_ctrl                = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic pcw, ifw, bub, fl;
    logic [31:0] tgt, ins;
    logic mr;
    logic [4:0] rd;
    logic [CW-1:0] c;
    logic [31:0] e_pc, e_ifpc, e_ins;
    logic e_ifv, e_exv;
    logic [4:0] e_rd;
    logic e_mr;
    logic [CW-1:0] e_c;
    logic e_err;
    int e_st, e_bu, e_fl;
  } vec_t;

  vec_t tbl[12];

  // Reference model state
  logic [31:0]   m_pc, m_ifpc, m_ins;
  logic          m_ifv, m_exv, m_mr, m_err;
  logic [4:0]    m_rd;
  logic [CW-1:0] m_c;
  int            m_st, m_bu, m_fl;

  function automatic int sat_inc(input int v);
    return (v < SAT) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_ifpc = 0; m_ins = NOP; m_ifv = 0;
    m_exv = 0; m_mr = 0; m_rd = 0; m_c = 0; m_err = 0;
    m_st = 0; m_bu = 0; m_fl = 0;
  endtask

  // Next state from the documented rules, using the model's pre-edge values.
  task automatic model_step();
    logic [31:0] pc0;
    logic        ifv0, go, fl;
    if (rst) begin
      model_reset();
      return;
    end
    pc0  = m_pc;
    ifv0 = m_ifv;
    go   = ctl.PC_Write_i;
    fl   = ctl.Flush_i && go;
    if (go) m_pc = fl ? ctl.Branch_Target_i : pc0 + 32'd4;
    if (ctl.IF_ID_Write_i) begin
      m_ifpc = pc0;
      m_ins  = fl ? NOP : instr;
      m_ifv  = !fl;
    end
    if (ctl.Bubble_Insertion_i) begin
      m_c = 0; m_mr = 0; m_rd = 0; m_exv = 0;
    end else begin
      m_c = id_ctrl; m_mr = id_mr; m_rd = id_rd; m_exv = ifv0;
    end
    if (!go) m_st = sat_inc(m_st);
    if (ctl.Bubble_Insertion_i) m_bu = sat_inc(m_bu);
    if (fl) m_fl = sat_inc(m_fl);
    if ((ctl.PC_Write_i != ctl.IF_ID_Write_i) || (ctl.Bubble_Insertion_i == ctl.PC_Write_i))
      m_err = 1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},     pc,             m_pc);
    check({tag, ".ifpc"},   ifid_pc,        m_ifpc);
    check({tag, ".ifins"},  ifid_instr,     m_ins);
    check({tag, ".ifv"},    {31'd0, ifid_v}, {31'd0, m_ifv});
    check({tag, ".exv"},    {31'd0, ex_v},   {31'd0, m_exv});
    check({tag, ".exmr"},   {31'd0, ex_mr},  {31'd0, m_mr});
    check({tag, ".exrd"},   {27'd0, ex_rd},  {27'd0, m_rd});
    check({tag, ".exc"},    32'(ex_ctrl),   32'(m_c));
    check({tag, ".err"},    {31'd0, err},    {31'd0, m_err});
    check({tag, ".st"},     32'(st_cnt),    32'(m_st));
    check({tag, ".bu"},     32'(bu_cnt),    32'(m_bu));
    check({tag, ".fl"},     32'(fl_cnt),    32'(m_fl));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".pc"},    pc, 32'h0);
    check({tag, ".ifpc"},  ifid_pc, 32'h0);
    check({tag, ".ifins"}, ifid_instr, NOP);
    check({tag, ".ifv"},   {31'd0, ifid_v}, 32'd0);
    check({tag, ".ex"},    {ex_v, ex_mr, ex_rd, ex_ctrl}, 32'd0);
    check({tag, ".cnt"},   {st_cnt, bu_cnt, fl_cnt}, 32'd0);
    check({tag, ".err"},   {31'd0, err}, 32'd0);
  endtask

  initial begin
    //           pcw ifw bub fl  tgt           ins           mr rd     c      e_pc          e_ifpc        e_ins         ifv exv e_rd  mr e_c    err st bu fl
    tbl[0]  = '{1, 1, 0, 0, 32'h0,        32'h0050_0093, 0, 5'd1,  8'h11, 32'h4,        32'h0,        32'h0050_0093, 1, 0, 5'd1,  0, 8'h11, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 32'h0,        32'h00A0_0113, 1, 5'd5,  8'h22, 32'h8,        32'h4,        32'h00A0_0113, 1, 1, 5'd5,  1, 8'h22, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 1, 0, 32'h0,        32'hDEAD_BEEF, 0, 5'd7,  8'h33, 32'h8,        32'h4,        32'h00A0_0113, 1, 0, 5'd0,  0, 8'h00, 0, 1, 1, 0};
    tbl[3]  = '{1, 1, 0, 0, 32'h0,        32'h00C5_8533, 0, 5'd10, 8'h44, 32'hC,        32'h8,        32'h00C5_8533, 1, 1, 5'd10, 0, 8'h44, 0, 1, 1, 0};
    tbl[4]  = '{1, 1, 0, 1, 32'h40,       32'h1234_5678, 0, 5'd0,  8'h00, 32'h40,       32'hC,        NOP,           0, 1, 5'd0,  0, 8'h00, 0, 1, 1, 1};
    tbl[5]  = '{1, 1, 0, 1, 32'h100,      32'h1111_1111, 0, 5'd3,  8'h55, 32'h100,      32'h40,       NOP,           0, 0, 5'd3,  0, 8'h55, 0, 1, 1, 2};
    tbl[6]  = '{0, 0, 1, 1, 32'h200,      32'h2222_2222, 0, 5'd4,  8'hAA, 32'h100,      32'h40,       NOP,           0, 0, 5'd0,  0, 8'h00, 0, 2, 2, 2};
    tbl[7]  = '{1, 0, 0, 0, 32'h0,        32'h3333_3333, 0, 5'd6,  8'h66, 32'h104,      32'h40,       NOP,           0, 0, 5'd6,  0, 8'h66, 1, 2, 2, 2};
    tbl[8]  = '{1, 1, 0, 0, 32'h0,        32'h4444_4444, 0, 5'd8,  8'h77, 32'h108,      32'h104,      32'h4444_4444, 1, 0, 5'd8,  0, 8'h77, 1, 2, 2, 2};
    tbl[9]  = '{1, 1, 1, 1, 32'h300,      32'h5555_0000, 1, 5'd9,  8'hEE, 32'h300,      32'h108,      NOP,           0, 0, 5'd0,  0, 8'h00, 1, 2, 3, 3};
    tbl[10] = '{1, 1, 0, 1, 32'hFFFF_FFFC, 32'h5555_5555, 0, 5'd11, 8'h88, 32'hFFFF_FFFC, 32'h300,      NOP,           0, 0, 5'd11, 0, 8'h88, 1, 2, 3, 4};
    tbl[11] = '{1, 1, 0, 0, 32'h0,        32'h6666_6666, 0, 5'd12, 8'h99, 32'h0,        32'hFFFF_FFFC, 32'h6666_6666, 1, 0, 5'd12, 0, 8'h99, 1, 2, 3, 4};

    rst = 1'b1;
    drive(1, 1, 0, 0, 32'h0, 32'h0, 0, 5'd0, '0);
    tick(); tick();
    check_reset_state("reset");
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      drive(tbl[i].pcw, tbl[i].ifw, tbl[i].bub, tbl[i].fl, tbl[i].tgt, tbl[i].ins,
            tbl[i].mr, tbl[i].rd, tbl[i].c);
      tick();
      check({t, ".pc"},    pc, tbl[i].e_pc);
      check({t, ".ifpc"},  ifid_pc, tbl[i].e_ifpc);
      check({t, ".ifins"}, ifid_instr, tbl[i].e_ins);
      check({t, ".ifv"},   {31'd0, ifid_v}, {31'd0, tbl[i].e_ifv});
      check({t, ".exv"},   {31'd0, ex_v}, {31'd0, tbl[i].e_exv});
      check({t, ".exrd"},  {27'd0, ex_rd}, {27'd0, tbl[i].e_rd});
      check({t, ".exmr"},  {31'd0, ex_mr}, {31'd0, tbl[i].e_mr});
      check({t, ".exc"},   32'(ex_ctrl), 32'(tbl[i].e_c));
      check({t, ".err"},   {31'd0, err}, {31'd0, tbl[i].e_err});
      check({t, ".st"},    32'(st_cnt), 32'(tbl[i].e_st));
      check({t, ".bu"},    32'(bu_cnt), 32'(tbl[i].e_bu));
      check({t, ".fl"},    32'(fl_cnt), 32'(tbl[i].e_fl));
    end

    // Sticky error survives consistent traffic, then reset clears it
    drive(1, 1, 0, 0, 32'h0, 32'h0, 0, 5'd0, '0);
    tick();
    check("sticky.err", {31'd0, err}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("rst_clr");

    // Long stall saturates the 4-bit counters; reset mid-stall clears everything
    drive(0, 0, 1, 0, 32'h0, 32'hABCD_0000, 0, 5'd2, 8'h01);
    for (int i = 0; i < 20; i++) tick();
    check("sat.st", 32'(st_cnt), 32'd15);
    check("sat.bu", 32'(bu_cnt), 32'd15);
    check("sat.pc", pc, 32'h0);
    tick();
    check("sat.st_hold", 32'(st_cnt), 32'd15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("rst_stall");

    // Randomized traffic against the reference model
    model_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      int unsigned r;
      logic [31:0] tgt;
      r   = $urandom_range(0, 99);
      tgt = $urandom & 32'hFFFF_FFFC;
      if (r < 55)
        drive(1, 1, 0, ($urandom_range(0, 4) == 0), tgt, $urandom, 1'($urandom),
              5'($urandom), CW'($urandom));
      else if (r < 78)
        drive(0, 0, 1, 1'($urandom), tgt, $urandom, 1'($urandom), 5'($urandom), CW'($urandom));
      else if (r < 84)
        drive(1, 1, 1, 1, tgt, $urandom, 1'($urandom), 5'($urandom), CW'($urandom));
      else
        drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), tgt, $urandom,
              1'($urandom), 5'($urandom), CW'($urandom));
      rst = ($urandom_range(0, 49) == 0);
      model_step();
      tick();
      check_model($sformatf("rnd%0d", cyc));
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
